// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end sharing one sequential
// Booth multiplier among NUM_REQ requesters, with a watchdog.
//
// Ports:
//   clk, reset         rising-edge clock, async active-high reset
//   req                per-requester request level
//   req_multiplicand   packed operands, slice i belongs to req[i]
//   req_multiplier     packed operands, slice i belongs to req[i]
//   grant              one-hot pulse, operands of that slice latched
//   rsp_valid          pulse, rsp_id/rsp_result/rsp_error valid
//   rsp_id             owner of the response
//   rsp_result         signed product, 0 on watchdog error
//   rsp_error          watchdog expired
//   busy               FSM not idle
//   mul_*              handshake to/from the shared multiplier
`timescale 1ns/1ps
module mult_arbiter #(
  parameter int WIDTH        = 4,
  parameter int NUM_REQ      = 4,
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = 64,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_multiplicand,
  input  logic [NUM_REQ*WIDTH-1:0] req_multiplier,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [2*WIDTH-1:0]       rsp_result,
  output logic                     rsp_error,
  output logic                     busy,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_multiplicand,
  output logic [WIDTH-1:0]         mul_multiplier,
  input  logic [2*WIDTH-1:0]       mul_result,
  input  logic                     mul_finished
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int SCW =
    (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE, LOAD, WAIT, RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr;
  logic [IDW-1:0] rr_next;
  logic [WDW-1:0] wd;
  logic [SCW-1:0] scnt;

  logic           pick_ok;
  logic [IDW-1:0] pick;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // First set req bit at or above rr, wrapping.
  always_comb begin
    int s;
    pick_ok = 1'b0;
    pick    = '0;
    s       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(rr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (!pick_ok && req[s]) begin
        pick_ok = 1'b1;
        pick    = IDW'(s);
      end
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDW'(i)) begin
        op_a = req_multiplicand[i*WIDTH +: WIDTH];
        op_b = req_multiplier[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    if (rsp_id == IDW'(NUM_REQ - 1))
      rr_next = '0;
    else
      rr_next = rsp_id + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      rr               <= '0;
      wd               <= '0;
      scnt             <= '0;
      grant            <= '0;
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
      rsp_result       <= '0;
      rsp_error        <= 1'b0;
      busy             <= 1'b0;
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
    end else begin
      grant     <= '0;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            state            <= LOAD;
            busy             <= 1'b1;
            grant            <= NUM_REQ'(1) << pick;
            rsp_id           <= pick;
            mul_multiplicand <= op_a;
            mul_multiplier   <= op_b;
            mul_start        <= 1'b1;
            scnt             <= '0;
          end
        end
        LOAD: begin
          // finished is stale while start is high
          if (scnt == SCW'(START_CYCLES - 1)) begin
            mul_start <= 1'b0;
            wd        <= '0;
            state     <= WAIT;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        WAIT: begin
          wd <= wd + 1'b1;
          // finished beats a same-edge timeout
          if (mul_finished) begin
            rsp_result <= mul_result;
            rsp_error  <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            rsp_result <= '0;
            rsp_error  <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          rr    <= rr_next;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed vectors with a scoreboard monitor,
// behavioural sequential multiplier stands in for the real one.
`timescale 1ns/1ps
module tb_mult_arbiter;

  localparam int W   = 4;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   mcand = '0;
  logic [N*W-1:0]   mplr = '0;
  logic [N-1:0]     grant;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [2*W-1:0]   rsp_result;
  logic             rsp_error;
  logic             busy;
  logic             mul_start;
  logic [W-1:0]     mul_multiplicand;
  logic [W-1:0]     mul_multiplier;
  logic [2*W-1:0]   mul_result;
  logic             mul_finished;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       err;
  } rsp_t;

  rsp_t rq[$];
  int   gq[$];
  logic hang = 1'b0;
  int   mcnt;

  always #5 clk = ~clk;

  mult_arbiter #(
    .WIDTH(W), .NUM_REQ(N),
    .START_CYCLES(1), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_multiplicand(mcand),
    .req_multiplier(mplr),
    .grant(grant),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_result(rsp_result),
    .rsp_error(rsp_error),
    .busy(busy),
    .mul_start(mul_start),
    .mul_multiplicand(mul_multiplicand),
    .mul_multiplier(mul_multiplier),
    .mul_result(mul_result),
    .mul_finished(mul_finished)
  );

  // Multiplier stand-in: 4 cycles after start drops, or never if hang.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_finished <= 1'b0;
      mul_result   <= '0;
      mcnt         <= 0;
    end else if (mul_start) begin
      mul_finished <= 1'b0;
      mcnt         <= 4;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !hang) begin
        mul_finished <= 1'b1;
        mul_result   <= $signed(mul_multiplicand)
                      * $signed(mul_multiplier);
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (|grant) begin
      if (gq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_unexpected: got %b expected none", grant);
      end else begin
        int e;
        e = gq.pop_front();
        chk("grant", 32'(grant), 32'(1) << e);
      end
    end
    if (rsp_valid) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d expected none",
                 rsp_id);
      end else begin
        rsp_t r;
        r = rq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(r.id));
        chk("rsp_result", 32'(rsp_result), 32'(r.res));
        chk("rsp_error", 32'(rsp_error), 32'(r.err));
      end
    end
  end

  task automatic set_op(input int i,
                        input logic [3:0] a,
                        input logic [3:0] b);
    mcand[i*W +: W] = a;
    mplr[i*W +: W]  = b;
  endtask

  task automatic expect_op(input int i,
                           input logic [7:0] res,
                           input logic err);
    rsp_t r;
    r.id  = i;
    r.res = res;
    r.err = err;
    gq.push_back(i);
    rq.push_back(r);
  endtask

  task automatic wait_grant(input logic drop);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (|grant) begin
        if (drop) req = req & ~grant;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout: got none expected grant");
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && rq.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got busy expected idle");
  endtask

  task automatic do_reset();
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_start", 32'(mul_start), 0);
    reset = 1'b0;

    // single request
    set_op(0, 4'h4, 4'h3);
    expect_op(0, 8'h0C, 1'b0);
    req = 4'b0001;
    wait_grant(1'b1);
    wait_idle();
    chk("rsp_hold", 32'(rsp_result), 32'h0C);

    // simultaneous requests
    do_reset();
    set_op(0, 4'h3, 4'h2);
    set_op(1, 4'h5, 4'h1);
    expect_op(0, 8'h06, 1'b0);
    expect_op(1, 8'h05, 1'b0);
    req = 4'b0011;
    wait_grant(1'b1);
    wait_grant(1'b1);
    wait_idle();

    // all held high, 8 operations
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 4'(i + 1), 4'h3);
    for (int n = 0; n < 8; n++)
      expect_op(n % N, 8'((n % N + 1) * 3), 1'b0);
    req = 4'b1111;
    for (int n = 0; n < 8; n++) wait_grant(1'b0);
    req = '0;
    wait_idle();

    // signed
    set_op(0, 4'hD, 4'h4);
    expect_op(0, 8'hF4, 1'b0);
    req = 4'b0001;
    wait_grant(1'b1);
    wait_idle();

    // watchdog
    hang = 1'b1;
    set_op(1, 4'h5, 4'h5);
    expect_op(1, 8'h00, 1'b1);
    req = 4'b0010;
    wait_grant(1'b1);
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    chk("timeout_latency", 32'(lat), 17);
    wait_idle();
    hang = 1'b0;
    set_op(1, 4'h7, 4'hF);
    expect_op(1, 8'hF9, 1'b0);
    req = 4'b0010;
    wait_grant(1'b1);
    wait_idle();

    // reset mid-WAIT
    hang = 1'b1;
    set_op(3, 4'h2, 4'h2);
    gq.push_back(3);
    req = 4'b1000;
    wait_grant(1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_mul_a", 32'(mul_multiplicand), 0);
    chk("arst_mul_b", 32'(mul_multiplier), 0);
    chk("arst_rsp_result", 32'(rsp_result), 0);
    chk("arst_rsp_id", 32'(rsp_id), 0);
    chk("arst_mul_start", 32'(mul_start), 0);
    @(negedge clk);
    reset = 1'b0;
    hang  = 1'b0;
    repeat (5) @(negedge clk);
    set_op(2, 4'h6, 4'hD);
    expect_op(2, 8'hEE, 1'b0);
    req = 4'b0100;
    wait_grant(1'b1);
    wait_idle();
    chk("grants_consumed", 32'(gq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
